// File: rtl/gpio_pkg.sv
// GPIO peripheral shared definitions: register offsets, register-select enum, address decode.
package gpio_pkg;

    localparam int unsigned GPIO_ADDR_W = 4;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_LED_OFS  = 4'h0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_BTN_OFS  = 4'h4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_EDGE_OFS = 4'h8;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_MASK_OFS = 4'hC;

    typedef enum logic [1:0] {
        REG_LED  = 2'd0,
        REG_BTN  = 2'd1,
        REG_EDGE = 2'd2,
        REG_MASK = 2'd3
    } gpio_reg_e;

    // Map the word index (byte address bits [3:2]) onto a register select.
    function automatic gpio_reg_e gpio_decode(input logic [1:0] word);
        logic [GPIO_ADDR_W-1:0] ofs;
        ofs = {word, 2'b00};
        case (ofs)
            GPIO_LED_OFS:  return REG_LED;
            GPIO_BTN_OFS:  return REG_BTN;
            GPIO_EDGE_OFS: return REG_EDGE;
            GPIO_MASK_OFS: return REG_MASK;
            default:       return REG_LED;
        endcase
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-bit button conditioner: 2-flop synchroniser followed by a hold-time debounce counter.
// Ports:
//   clk, rstb  clock, asynchronous active-low reset
//   btn_i      raw asynchronous button level
//   d_o        debounced level (registered)
//   rise_c     one-cycle pulse, high when d_o is about to go 0->1 on the next edge
//              (present only when GPIO_IRQ_EN is defined)
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rstb,
    input  logic btn_i,
    output logic d_o
`ifdef GPIO_IRQ_EN
    ,
    output logic rise_c
`endif
);

    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES - 1;

    logic             sync1_q;
    logic             s_q;
    logic             d_q;
    logic             d_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles of disagreement; accept the new level on the last one.
    always_comb begin
        d_d   = d_q;
        cnt_d = '0;
        if (s_q != d_q) begin
            if (cnt_q == CNT_W'(CNT_MAX)) begin
                d_d = s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            d_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            s_q     <= sync1_q;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_o = d_q;

`ifdef GPIO_IRQ_EN
    assign rise_c = d_d & ~d_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO peripheral: LED output register, debounced button inputs,
// optional sticky rising-edge capture with masked level interrupt.
// Optional feature macro: GPIO_IRQ_EN (EDGE/MASK registers and irq).
// Ports:
//   clk, rstb                  clock, asynchronous active-low reset
//   bus_sel/we/addr/wdata      single-cycle access strobe, direction, byte address, write data
//   bus_rdata/bus_ready        read data and one-cycle completion pulse, one cycle after bus_sel
//   btn                        raw button levels
//   led                        LED drive
//   irq                        level interrupt, |(EDGE & MASK) registered
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned N_LED           = 8,
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   bus_sel,
    input  logic                   bus_we,
    input  logic [GPIO_ADDR_W-1:0] bus_addr,
    input  logic [XLEN-1:0]        bus_wdata,
    output logic [XLEN-1:0]        bus_rdata,
    output logic                   bus_ready,
    input  logic [N_BTN-1:0]       btn,
    output logic [N_LED-1:0]       led,
    output logic                   irq
);

    logic [N_BTN-1:0] btn_db;
`ifdef GPIO_IRQ_EN
    logic [N_BTN-1:0] btn_rise_c;
`endif

    // Per-channel synchroniser + debounce.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rstb  (rstb),
            .btn_i (btn[gi]),
            .d_o   (btn_db[gi])
`ifdef GPIO_IRQ_EN
            ,
            .rise_c(btn_rise_c[gi])
`endif
        );
    end

    gpio_reg_e sel_c;
    logic      wr_c;
    logic      rd_c;

    assign sel_c = gpio_decode(bus_addr[3:2]);
    assign wr_c  = bus_sel & bus_we;
    assign rd_c  = bus_sel & ~bus_we;

    // Byte-lane bits and upper write-data bits carry no state.
    logic unused_c;
    assign unused_c = ^{bus_addr[1:0], bus_wdata};

    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  rdata_d;
    logic             ready_q;

`ifdef GPIO_IRQ_EN
    logic [N_BTN-1:0] edge_q;
    logic [N_BTN-1:0] edge_d;
    logic [N_BTN-1:0] mask_q;
    logic [N_BTN-1:0] mask_d;
    logic             irq_q;
    logic             irq_d;
`endif

    // Read mux; write accesses return zero.
    always_comb begin
        rdata_d = '0;
        if (rd_c) begin
            case (sel_c)
                REG_LED:  rdata_d = XLEN'(led_q);
                REG_BTN:  rdata_d = XLEN'(btn_db);
`ifdef GPIO_IRQ_EN
                REG_EDGE: rdata_d = XLEN'(edge_q);
                REG_MASK: rdata_d = XLEN'(mask_q);
`endif
                default:  rdata_d = '0;
            endcase
        end
    end

    // Register next-state: new edges win over a simultaneous W1C clear.
    always_comb begin
        led_d = led_q;
        if (wr_c && (sel_c == REG_LED)) begin
            led_d = bus_wdata[N_LED-1:0];
        end
`ifdef GPIO_IRQ_EN
        edge_d = edge_q;
        mask_d = mask_q;
        irq_d  = |(edge_q & mask_q);
        if (wr_c && (sel_c == REG_EDGE)) begin
            edge_d = edge_q & ~bus_wdata[N_BTN-1:0];
        end
        edge_d = edge_d | btn_rise_c;
        if (wr_c && (sel_c == REG_MASK)) begin
            mask_d = bus_wdata[N_BTN-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            led_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            rdata_q <= rdata_d;
            ready_q <= bus_sel;
        end
    end

`ifdef GPIO_IRQ_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign led       = led_q;
    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;

endmodule
